// File: rtl/ctrl_pkg.sv
// Shared encodings for the multi-cycle control unit:
// states, ALU ops, opcodes, functs, mux selects, instruction classes.
package ctrl_pkg;

  localparam logic [3:0] S_IF     = 4'd0;
  localparam logic [3:0] S_ID     = 4'd1;
  localparam logic [3:0] S_EX_R   = 4'd2;
  localparam logic [3:0] S_EX_I   = 4'd3;
  localparam logic [3:0] S_EX_M   = 4'd4;
  localparam logic [3:0] S_MEM_RD = 4'd5;
  localparam logic [3:0] S_MEM_WR = 4'd6;
  localparam logic [3:0] S_WB_ALU = 4'd7;
  localparam logic [3:0] S_WB_MEM = 4'd8;
  localparam logic [3:0] S_BR     = 4'd9;
  localparam logic [3:0] S_JMP    = 4'd10;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_XOR = 3'b010;
  localparam logic [2:0] ALU_NOR = 3'b011;
  localparam logic [2:0] ALU_ADD = 3'b100;
  localparam logic [2:0] ALU_SUB = 3'b101;
  localparam logic [2:0] ALU_SLT = 3'b110;
  localparam logic [2:0] ALU_SLL = 3'b111;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_SLTIU = 6'b001011;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_XORI  = 6'b001110;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_XOR = 6'b100110;
  localparam logic [5:0] FN_NOR = 6'b100111;
  localparam logic [5:0] FN_SLT = 6'b101011;
  localparam logic [5:0] FN_SLL = 6'b000100;
  localparam logic [5:0] FN_JR  = 6'b001000;

  localparam logic [1:0] WR_RD  = 2'b00;
  localparam logic [1:0] WR_RT  = 2'b01;
  localparam logic [1:0] WR_R31 = 2'b10;

  localparam logic [1:0] WD_ALU = 2'b00;
  localparam logic [1:0] WD_MEM = 2'b01;
  localparam logic [1:0] WD_PC4 = 2'b10;

  localparam logic [1:0] PC_PC4 = 2'b00;
  localparam logic [1:0] PC_RS  = 2'b01;
  localparam logic [1:0] PC_BR  = 2'b10;
  localparam logic [1:0] PC_JMP = 2'b11;

  typedef enum logic [3:0] {
    C_ILL, C_R, C_JR, C_I, C_LW,
    C_SW, C_BEQ, C_BNE, C_J, C_JAL
  } inst_class_t;

endpackage

// File: rtl/inst_class_dec.sv
// Combinational instruction classifier: opcode/funct to
// instruction class and the ALU operation used in EX.
module inst_class_dec
  import ctrl_pkg::*;
(
  input  logic [31:0]  inst,
  output inst_class_t  cls,
  output logic [2:0]   alu_op
);

  logic [5:0] op;
  logic [5:0] fn;
  logic       unused_bits;

  assign op = inst[31:26];
  assign fn = inst[5:0];
  assign unused_bits = ^inst[25:6];

  always_comb begin
    cls    = C_ILL;
    alu_op = ALU_ADD;
    case (op)
      OP_RTYPE: begin
        cls = C_R;
        case (fn)
          FN_ADD:  alu_op = ALU_ADD;
          FN_SUB:  alu_op = ALU_SUB;
          FN_AND:  alu_op = ALU_AND;
          FN_OR:   alu_op = ALU_OR;
          FN_XOR:  alu_op = ALU_XOR;
          FN_NOR:  alu_op = ALU_NOR;
          FN_SLT:  alu_op = ALU_SLT;
          FN_SLL:  alu_op = ALU_SLL;
          FN_JR:   cls = C_JR;
          default: cls = C_ILL;
        endcase
      end
      OP_ADDI:  begin cls = C_I; alu_op = ALU_ADD; end
      OP_ANDI:  begin cls = C_I; alu_op = ALU_AND; end
      OP_XORI:  begin cls = C_I; alu_op = ALU_XOR; end
      OP_SLTIU: begin cls = C_I; alu_op = ALU_SLT; end
      OP_LW:    cls = C_LW;
      OP_SW:    cls = C_SW;
      OP_BEQ:   cls = C_BEQ;
      OP_BNE:   cls = C_BNE;
      OP_J:     cls = C_J;
      OP_JAL:   cls = C_JAL;
      default:  cls = C_ILL;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle MIPS-subset control FSM: state register,
// next-state logic and Moore output decode.
module multicycle_ctrl
  import ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [31:0] inst,
  input  logic       ZF,
  output logic       PC_Write,
  output logic       IR_Write,
  output logic       Write_Reg,
  output logic       Mem_Write,
  output logic [2:0] ALU_OP,
  output logic       rt_imm_s,
  output logic       imm_s,
  output logic [1:0] w_r_s,
  output logic [1:0] wr_data_s,
  output logic [1:0] PC_s,
  output logic [3:0] state,
  output logic       inst_done,
  output logic       illegal
);

  inst_class_t cls;
  logic [2:0]  dec_op;
  logic [3:0]  next;

  inst_class_dec u_dec (
    .inst   (inst),
    .cls    (cls),
    .alu_op (dec_op)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IF;
    else     state <= next;
  end

  always_comb begin
    next = S_IF;
    case (state)
      S_IF: next = S_ID;
      S_ID: begin
        case (cls)
          C_R:               next = S_EX_R;
          C_I:               next = S_EX_I;
          C_LW, C_SW:        next = S_EX_M;
          C_BEQ, C_BNE:      next = S_BR;
          C_JR, C_J, C_JAL:  next = S_JMP;
          default:           next = S_IF;
        endcase
      end
      S_EX_R, S_EX_I: next = S_WB_ALU;
      S_EX_M:   next = (cls == C_SW) ? S_MEM_WR : S_MEM_RD;
      S_MEM_RD: next = S_WB_MEM;
      default:  next = S_IF;
    endcase
  end

  always_comb begin
    PC_Write  = 1'b0;
    IR_Write  = 1'b0;
    Write_Reg = 1'b0;
    Mem_Write = 1'b0;
    ALU_OP    = ALU_ADD;
    rt_imm_s  = 1'b0;
    imm_s     = 1'b0;
    w_r_s     = WR_RD;
    wr_data_s = WD_ALU;
    PC_s      = PC_PC4;
    inst_done = 1'b0;
    illegal   = 1'b0;
    case (state)
      S_IF: begin
        IR_Write = 1'b1;
        PC_Write = 1'b1;
      end
      S_ID: illegal = (cls == C_ILL);
      S_EX_R: ALU_OP = dec_op;
      S_EX_I: begin
        ALU_OP   = dec_op;
        rt_imm_s = 1'b1;
        imm_s    = (dec_op == ALU_ADD);
      end
      S_EX_M: begin
        rt_imm_s = 1'b1;
        imm_s    = 1'b1;
      end
      S_MEM_WR: begin
        Mem_Write = 1'b1;
        inst_done = 1'b1;
      end
      S_WB_ALU: begin
        Write_Reg = 1'b1;
        w_r_s     = (cls == C_I) ? WR_RT : WR_RD;
        inst_done = 1'b1;
      end
      S_WB_MEM: begin
        Write_Reg = 1'b1;
        wr_data_s = WD_MEM;
        w_r_s     = WR_RT;
        inst_done = 1'b1;
      end
      // Select is fixed so only the write enable sees ZF
      S_BR: begin
        ALU_OP    = ALU_SUB;
        PC_s      = PC_BR;
        PC_Write  = (cls == C_BEQ && ZF) || (cls == C_BNE && !ZF);
        inst_done = 1'b1;
      end
      S_JMP: begin
        PC_Write  = 1'b1;
        inst_done = 1'b1;
        PC_s      = (cls == C_JR) ? PC_RS : PC_JMP;
        if (cls == C_JAL) begin
          Write_Reg = 1'b1;
          w_r_s     = WR_R31;
          wr_data_s = WD_PC4;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed vector bench for multicycle_ctrl: per-cycle
// state and control expectations plus a mid-store reset.
module tb_multicycle_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] inst = 32'h0;
  logic        ZF = 1'b0;
  logic        PC_Write, IR_Write, Write_Reg, Mem_Write;
  logic [2:0]  ALU_OP;
  logic        rt_imm_s, imm_s;
  logic [1:0]  w_r_s, wr_data_s, PC_s;
  logic [3:0]  state;
  logic        inst_done, illegal;

  int checks = 0;
  int errors = 0;

  multicycle_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .inst      (inst),
    .ZF        (ZF),
    .PC_Write  (PC_Write),
    .IR_Write  (IR_Write),
    .Write_Reg (Write_Reg),
    .Mem_Write (Mem_Write),
    .ALU_OP    (ALU_OP),
    .rt_imm_s  (rt_imm_s),
    .imm_s     (imm_s),
    .w_r_s     (w_r_s),
    .wr_data_s (wr_data_s),
    .PC_s      (PC_s),
    .state     (state),
    .inst_done (inst_done),
    .illegal   (illegal)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] inst;
    logic        zf;
    logic [3:0]  st;
    logic [16:0] ctl;
  } vec_t;

  vec_t tv[$];

  logic [16:0] act;
  assign act = {PC_Write, IR_Write, Write_Reg, Mem_Write, ALU_OP,
                rt_imm_s, imm_s, w_r_s, wr_data_s, PC_s,
                inst_done, illegal};

  function automatic logic [16:0] o(
    input logic pcw, irw, wr, mw,
    input logic [2:0] op,
    input logic rti, ims,
    input logic [1:0] wrs, wds, pcs,
    input logic done, ill);
    return {pcw, irw, wr, mw, op, rti, ims, wrs, wds, pcs, done, ill};
  endfunction

  task automatic pv(input logic [31:0] i, input logic z,
                    input logic [3:0] s, input logic [16:0] c);
    vec_t v;
    v.inst = i; v.zf = z; v.st = s; v.ctl = c;
    tv.push_back(v);
  endtask

  task automatic chk(input string nm, input logic [31:0] got,
                     input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %0h want %0h", nm, got, want);
    end
  endtask

  logic [16:0] c_if, c_id, c_mid;

  task automatic alu_r(input logic [31:0] i, input logic [2:0] op);
    pv(i, 1'b1, 4'd0, c_if);
    pv(i, 1'b1, 4'd1, c_id);
    pv(i, 1'b1, 4'd2, o(0,0,0,0,op,0,0,2'b00,2'b00,2'b00,0,0));
    pv(i, 1'b1, 4'd7, o(0,0,1,0,3'b100,0,0,2'b00,2'b00,2'b00,1,0));
  endtask

  task automatic alu_i(input logic [31:0] i, input logic [2:0] op,
                       input logic ims);
    pv(i, 1'b0, 4'd0, c_if);
    pv(i, 1'b0, 4'd1, c_id);
    pv(i, 1'b0, 4'd3, o(0,0,0,0,op,1,ims,2'b00,2'b00,2'b00,0,0));
    pv(i, 1'b0, 4'd7, o(0,0,1,0,3'b100,0,0,2'b01,2'b00,2'b00,1,0));
  endtask

  task automatic ctl3(input logic [31:0] i, input logic z,
                      input logic [3:0] s, input logic [16:0] c);
    pv(i, z, 4'd0, c_if);
    pv(i, z, 4'd1, c_id);
    pv(i, z, s, c);
  endtask

  initial begin
    c_if  = o(1,1,0,0,3'b100,0,0,2'b00,2'b00,2'b00,0,0);
    c_id  = o(0,0,0,0,3'b100,0,0,2'b00,2'b00,2'b00,0,0);
    c_mid = o(0,0,0,0,3'b100,1,1,2'b00,2'b00,2'b00,0,0);

    alu_r(32'h00221820, 3'b100);
    alu_r(32'h00221822, 3'b101);
    alu_r(32'h00221827, 3'b011);
    alu_r(32'h0022182B, 3'b110);
    alu_r(32'h00221804, 3'b111);
    alu_i(32'h2022FFFF, 3'b100, 1'b1);
    alu_i(32'h302200FF, 3'b000, 1'b0);
    alu_i(32'h382200FF, 3'b010, 1'b0);
    alu_i(32'h2C220005, 3'b110, 1'b0);

    pv(32'h8C250004, 1'b1, 4'd0, c_if);
    pv(32'h8C250004, 1'b1, 4'd1, c_id);
    pv(32'h8C250004, 1'b1, 4'd4, c_mid);
    pv(32'h8C250004, 1'b1, 4'd5, c_id);
    pv(32'h8C250004, 1'b1, 4'd8,
       o(0,0,1,0,3'b100,0,0,2'b01,2'b01,2'b00,1,0));

    pv(32'hAC250004, 1'b0, 4'd0, c_if);
    pv(32'hAC250004, 1'b0, 4'd1, c_id);
    pv(32'hAC250004, 1'b0, 4'd4, c_mid);
    pv(32'hAC250004, 1'b0, 4'd6,
       o(0,0,0,1,3'b100,0,0,2'b00,2'b00,2'b00,1,0));

    ctl3(32'h10220003, 1'b1, 4'd9,
         o(1,0,0,0,3'b101,0,0,2'b00,2'b00,2'b10,1,0));
    ctl3(32'h10220003, 1'b0, 4'd9,
         o(0,0,0,0,3'b101,0,0,2'b00,2'b00,2'b10,1,0));
    ctl3(32'h14220003, 1'b1, 4'd9,
         o(0,0,0,0,3'b101,0,0,2'b00,2'b00,2'b10,1,0));
    ctl3(32'h14220003, 1'b0, 4'd9,
         o(1,0,0,0,3'b101,0,0,2'b00,2'b00,2'b10,1,0));
    ctl3(32'h08000010, 1'b0, 4'd10,
         o(1,0,0,0,3'b100,0,0,2'b00,2'b00,2'b11,1,0));
    ctl3(32'h0C000010, 1'b1, 4'd10,
         o(1,0,1,0,3'b100,0,0,2'b10,2'b10,2'b11,1,0));
    ctl3(32'h03E00008, 1'b0, 4'd10,
         o(1,0,0,0,3'b100,0,0,2'b00,2'b00,2'b01,1,0));

    pv(32'hFC000000, 1'b0, 4'd0, c_if);
    pv(32'hFC000000, 1'b0, 4'd1,
       o(0,0,0,0,3'b100,0,0,2'b00,2'b00,2'b00,0,1));
    pv(32'h0000003F, 1'b0, 4'd0, c_if);
    pv(32'h0000003F, 1'b0, 4'd1,
       o(0,0,0,0,3'b100,0,0,2'b00,2'b00,2'b00,0,1));
    pv(32'h00221820, 1'b0, 4'd0, c_if);

    #12;
    chk("reset_state", {28'd0, state}, 32'd0);
    chk("reset_ctl", {15'd0, act}, {15'd0, c_if});

    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < tv.size(); k++) begin
      inst = tv[k].inst;
      ZF   = tv[k].zf;
      #1;
      chk($sformatf("v%0d_state", k), {28'd0, state}, {28'd0, tv[k].st});
      chk($sformatf("v%0d_ctl", k), {15'd0, act}, {15'd0, tv[k].ctl});
      @(negedge clk);
    end

    rst = 1'b1;
    #1;
    chk("rst_again_state", {28'd0, state}, 32'd0);
    @(negedge clk);
    rst  = 1'b0;
    inst = 32'hAC250004;
    #1;
    chk("sw_if", {28'd0, state}, 32'd0);
    @(negedge clk);
    chk("sw_id", {28'd0, state}, 32'd1);
    @(negedge clk);
    chk("sw_exm", {28'd0, state}, 32'd4);
    @(negedge clk);
    chk("sw_memwr", {28'd0, state}, 32'd6);
    chk("sw_memwr_we", {31'd0, Mem_Write}, 32'd1);
    #2;
    rst = 1'b1;
    #1;
    chk("mid_rst_we", {31'd0, Mem_Write}, 32'd0);
    chk("mid_rst_state", {28'd0, state}, 32'd0);
    chk("mid_rst_ctl", {15'd0, act}, {15'd0, c_if});
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_id", {28'd0, state}, 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
